hht_mem_server: RTL and testbench

HHT_MEM_SERVER -- requirements
Module: hht_mem_server

---
 rtl/hht_mem_server.sv | 153 +++++++++++++++
 tb/tb_hht_mem_server.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/hht_mem_server.sv
// Memory and base-register server for the HHT: one preload write port, two independent read ports.
// Build option: define HHT_MEM_WAIT_EN to add WAIT_STATES extra response cycles per read.
module hht_mem_server #(
    parameter int unsigned MEM_AW      = 15,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [31:0] FILL        = 32'd99999
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        cpu_we,
    input  logic        cpu_sel,
    input  logic [31:0] cpu_waddr,
    input  logic [31:0] cpu_wdata,
    input  logic        req1,
    input  logic        req2,
    input  logic [31:0] addr1,
    input  logic [31:0] addr2,
    output logic [31:0] dataIn1,
    output logic [31:0] dataIn2,
    output logic        valid1,
    output logic        valid2,
    input  logic [4:0]  regaddr1,
    input  logic [4:0]  regaddr2,
    output logic [31:0] base_dat_a,
    output logic [31:0] base_dat_b
);

    localparam int unsigned MEM_WORDS = 1 << MEM_AW;

    if (WAIT_STATES > 15) begin : g_bad_wait_states
        $error("WAIT_STATES must be in the range 0-15");
    end
    if (MEM_AW < 1 || MEM_AW > 31) begin : g_bad_mem_aw
        $error("MEM_AW must be in the range 1-31");
    end

`ifdef HHT_MEM_WAIT_EN
    localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);
    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;
`else
    typedef enum logic [0:0] {StIdle, StResp} state_e;
`endif

    logic [31:0]          mem [MEM_WORDS];
    logic [MEM_WORDS-1:0] written_q;
    logic [31:0]          base_q [32];

    logic mem_we;

    // Writes beyond the backing store are dropped rather than aliased.
    assign mem_we = Rst && cpu_we && !cpu_sel && (cpu_waddr[31:MEM_AW] == '0);

    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem[cpu_waddr[MEM_AW-1:0]] <= cpu_wdata;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            written_q <= '0;
        end else if (mem_we) begin
            written_q[cpu_waddr[MEM_AW-1:0]] <= 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            for (int i = 0; i < 32; i++) begin
                base_q[i] <= '0;
            end
        end else if (cpu_we && cpu_sel) begin
            base_q[cpu_waddr[4:0]] <= cpu_wdata;
        end
    end

    assign base_dat_a = base_q[regaddr1];
    assign base_dat_b = base_q[regaddr2];

    logic [1:0]        req_v;
    logic [1:0]        valid_v;
    logic [1:0][31:0]  rd_v;
    logic [1:0][31:0]  out_v;

    assign req_v = {req2, req1};

    // Combinational lookup sees pre-edge contents, so a same-cycle write is not visible.
    assign rd_v[0] = ((addr1[31:MEM_AW] == '0) && written_q[addr1[MEM_AW-1:0]])
                     ? mem[addr1[MEM_AW-1:0]] : FILL;
    assign rd_v[1] = ((addr2[31:MEM_AW] == '0) && written_q[addr2[MEM_AW-1:0]])
                     ? mem[addr2[MEM_AW-1:0]] : FILL;

    for (genvar p = 0; p < 2; p++) begin : g_port
        state_e      state_q, state_d;
        logic [31:0] out_q;
`ifdef HHT_MEM_WAIT_EN
        logic [3:0]  cnt_q;
        logic [31:0] rd_q;
`endif

        always_comb begin
            state_d = state_q;
            unique case (state_q)
`ifdef HHT_MEM_WAIT_EN
                StIdle: if (req_v[p]) state_d = (WAIT_CNT == 4'd0) ? StResp : StWait;
                StWait: if (cnt_q == 4'd1) state_d = StResp;
`else
                StIdle: if (req_v[p]) state_d = StResp;
`endif
                StResp: state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end

        always_ff @(posedge Clk) begin
            if (!Rst) begin
                state_q <= StIdle;
                out_q   <= FILL;
`ifdef HHT_MEM_WAIT_EN
                cnt_q   <= '0;
                rd_q    <= FILL;
`endif
            end else begin
                state_q <= state_d;
`ifdef HHT_MEM_WAIT_EN
                if (state_q == StIdle && req_v[p]) begin
                    rd_q  <= rd_v[p];
                    cnt_q <= WAIT_CNT;
                end else if (state_q == StWait) begin
                    cnt_q <= cnt_q - 4'd1;
                end
                // Output only changes on entry to RESP so it holds between pulses.
                if (state_d == StResp && state_q != StResp) begin
                    out_q <= (state_q == StIdle) ? rd_v[p] : rd_q;
                end
`else
                if (state_q == StIdle && req_v[p]) begin
                    out_q <= rd_v[p];
                end
`endif
            end
        end

        assign valid_v[p] = (state_q == StResp);
        assign out_v[p]   = out_q;
    end

    assign valid1  = valid_v[0];
    assign valid2  = valid_v[1];
    assign dataIn1 = out_v[0];
    assign dataIn2 = out_v[1];

endmodule

// File: tb/tb_hht_mem_server.sv
// Directed self-checking bench for hht_mem_server; follows HHT_MEM_WAIT_EN for expected latency.
module tb_hht_mem_server;

`ifdef HHT_MEM_WAIT_EN
    localparam int WC = 2;
`else
    localparam int WC = 0;
`endif
    localparam logic [31:0] FILL = 32'd99999;

    logic        Clk, Rst;
    logic        cpu_we, cpu_sel;
    logic [31:0] cpu_waddr, cpu_wdata;
    logic        req1, req2;
    logic [31:0] addr1, addr2;
    logic [31:0] dataIn1, dataIn2;
    logic        valid1, valid2;
    logic [4:0]  regaddr1, regaddr2;
    logic [31:0] base_dat_a, base_dat_b;

    int n_checks = 0;
    int n_pass   = 0;

    hht_mem_server dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .cpu_we     (cpu_we),
        .cpu_sel    (cpu_sel),
        .cpu_waddr  (cpu_waddr),
        .cpu_wdata  (cpu_wdata),
        .req1       (req1),
        .req2       (req2),
        .addr1      (addr1),
        .addr2      (addr2),
        .dataIn1    (dataIn1),
        .dataIn2    (dataIn2),
        .valid1     (valid1),
        .valid2     (valid2),
        .regaddr1   (regaddr1),
        .regaddr2   (regaddr2),
        .base_dat_a (base_dat_a),
        .base_dat_b (base_dat_b)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic vld(input int p);
        return (p == 1) ? valid1 : valid2;
    endfunction

    function automatic logic [31:0] dat(input int p);
        return (p == 1) ? dataIn1 : dataIn2;
    endfunction

    task automatic write(input logic sel, input logic [31:0] a, input logic [31:0] d);
        cpu_we    = 1'b1;
        cpu_sel   = sel;
        cpu_waddr = a;
        cpu_wdata = d;
        tick();
        cpu_we = 1'b0;
    endtask

    task automatic start_req(input int p, input logic [31:0] a);
        if (p == 1) begin
            req1 = 1'b1;
            addr1 = a;
        end else begin
            req2 = 1'b1;
            addr2 = a;
        end
    endtask

    task automatic finish_read(input int p, input logic [31:0] exp, input string tag);
        logic early;
        tick();
        cpu_we = 1'b0;
        if (p == 1) req1 = 1'b0;
        else req2 = 1'b0;
        early = 1'b0;
        repeat (WC) begin
            if (vld(p)) early = 1'b1;
            tick();
        end
        check({tag, "_early"}, 32'(early), 32'd0);
        check({tag, "_valid"}, 32'(vld(p)), 32'd1);
        check({tag, "_data"}, dat(p), exp);
        tick();
        check({tag, "_pulse"}, 32'(vld(p)), 32'd0);
    endtask

    task automatic do_read(input int p, input logic [31:0] a, input logic [31:0] exp,
                           input string tag);
        start_req(p, a);
        finish_read(p, exp, tag);
    endtask

    initial begin
        logic [7:0] obs, expv;
        logic       saw;

        Rst = 1'b0;
        cpu_we = 1'b0; cpu_sel = 1'b0; cpu_waddr = '0; cpu_wdata = '0;
        req1 = 1'b0; req2 = 1'b0; addr1 = '0; addr2 = '0;
        regaddr1 = 5'd0; regaddr2 = 5'd0;
        tick();
        tick();
        Rst = 1'b1;

        check("rst_valid1", 32'(valid1), 32'd0);
        check("rst_valid2", 32'(valid2), 32'd0);
        check("rst_data1", dataIn1, FILL);
        check("rst_data2", dataIn2, FILL);
        check("rst_base_a", base_dat_a, 32'd0);

        write(1'b1, 32'd6, 32'd2440);
        write(1'b1, 32'd15, 32'd25940);
        regaddr1 = 5'd6;
        regaddr2 = 5'd15;
        #1;
        check("base_a", base_dat_a, 32'd2440);
        check("base_b", base_dat_b, 32'd25940);

        write(1'b0, 32'd25941, 32'd12);
        write(1'b0, 32'd126, 32'd44);
        write(1'b0, 32'd2441, 32'd12);
        write(1'b0, 32'd32767, 32'd3);
        write(1'b0, 32'd40000, 32'd5);
        write(1'b0, 32'd200, 32'd9);

        do_read(1, 32'd25941, 32'd12, "rd1");
        repeat (3) tick();
        check("hold1", dataIn1, 32'd12);
        do_read(2, 32'd126, 32'd44, "rd2");

        do_read(1, 32'd40000, FILL, "oor");
        do_read(2, 32'd500, FILL, "unwritten");
        do_read(1, 32'd7232, FILL, "no_alias");
        do_read(2, 32'd32767, 32'd3, "top_word");

        // Same-cycle write and read: old contents are returned.
        start_req(1, 32'd2441);
        cpu_we = 1'b1; cpu_sel = 1'b0; cpu_waddr = 32'd2441; cpu_wdata = 32'd77;
        finish_read(1, 32'd12, "coll");
        do_read(1, 32'd2441, 32'd77, "coll_after");
        start_req(2, 32'd600);
        cpu_we = 1'b1; cpu_sel = 1'b0; cpu_waddr = 32'd600; cpu_wdata = 32'd8;
        finish_read(2, FILL, "coll_new");

        start_req(1, 32'd25941);
        start_req(2, 32'd25941);
        tick();
        req1 = 1'b0; req2 = 1'b0;
        repeat (WC) tick();
        check("both_v1", 32'(valid1), 32'd1);
        check("both_v2", 32'(valid2), 32'd1);
        check("both_d1", dataIn1, 32'd12);
        check("both_d2", dataIn2, 32'd12);
        tick();

        // Held request: one response every 2+WC cycles.
        start_req(1, 32'd200);
        tick();
        obs = '0;
        expv = '0;
        for (int i = 0; i < 2 * (2 + WC); i++) begin
            obs[i]  = valid1;
            expv[i] = ((i % (2 + WC)) == WC);
            tick();
        end
        req1 = 1'b0;
        repeat (WC + 3) tick();
        check("hold_req_pattern", 32'(obs), 32'(expv));
        check("hold_req_data", dataIn1, 32'd9);

`ifdef HHT_MEM_WAIT_EN
        start_req(1, 32'd126);
        tick();
        req1 = 1'b0;
        Rst = 1'b0;
        tick();
        Rst = 1'b1;
`else
        start_req(1, 32'd126);
        Rst = 1'b0;
        tick();
        Rst = 1'b1;
        req1 = 1'b0;
`endif
        saw = 1'b0;
        for (int i = 0; i < WC + 4; i++) begin
            if (valid1) saw = 1'b1;
            tick();
        end
        check("abort_no_valid", 32'(saw), 32'd0);
        check("abort_data1", dataIn1, FILL);
        check("abort_data2", dataIn2, FILL);
        check("abort_base", base_dat_a, 32'd0);
        do_read(1, 32'd25941, FILL, "written_cleared");
        write(1'b0, 32'd126, 32'd55);
        do_read(1, 32'd126, 32'd55, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
